// File: rtl/seq_detector_param_if.sv
// Bus bundle for the programmable serial pattern detector.
// master: stimulus side (drives stream, pattern and control inputs).
// slave : the detector (drives the match pulse, count and active length).
interface seq_detector_param_if #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
);
  // stream
  logic               din;
  logic               din_valid;
  logic               overlap_en;
  // pattern programming
  logic               pat_load;
  logic [PAT_MAX-1:0] pat_in;
  logic [LEN_W-1:0]   pat_len;
  // counter control
  logic               count_clr;
  // results
  logic               dout;
  logic [CNT_W-1:0]   match_count;
  logic [LEN_W-1:0]   pat_len_q;

  modport master (
    output din, din_valid, overlap_en, pat_load, pat_in, pat_len, count_clr,
    input  dout, match_count, pat_len_q
  );

  modport slave (
    input  din, din_valid, overlap_en, pat_load, pat_in, pat_len, count_clr,
    output dout, match_count, pat_len_q
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial bit-stream detector with a runtime-loadable pattern of 1..PAT_MAX
// bits. Pattern bit [len-1] is the first bit received, bit [0] the last.
// A registered one-cycle pulse on dout marks each match and a saturating
// counter tallies them. Overlapping or non-overlapping detection is chosen
// per valid cycle through overlap_en.
module seq_detector_param #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              reset,
  seq_detector_param_if.slave bus
);

  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(PAT_MAX);
  localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(4);
  localparam logic [PAT_MAX-1:0] PAT_RST = PAT_MAX'(4'b1001);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  // state
  logic [PAT_MAX-1:0] pat_q, hist;
  logic [LEN_W-1:0]   len_q, fill;
  logic               dout_q;
  logic [CNT_W-1:0]   cnt_q;

  // next state
  logic [PAT_MAX-1:0] pat_n, hist_n;
  logic [LEN_W-1:0]   len_n, fill_n;
  logic               dout_n;
  logic [CNT_W-1:0]   cnt_n;

  // decode
  logic               load_ok;
  logic [PAT_MAX-1:0] shift_hist;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   fill_sat;
  logic [PAT_MAX-1:0] len_mask;
  logic               bits_eq;
  logic               match;

  // Decode this cycle's load legality, shifted history and match decision.
  // Only the low len_q bits take part in the compare; the mask blanks the
  // rest so stale history or pattern bits above the length never matter.
  always_comb begin
    load_ok    = bus.pat_load && (bus.pat_len != '0) && (bus.pat_len <= LEN_MAX);
    shift_hist = {hist[PAT_MAX-2:0], bus.din};
    fill_inc   = {1'b0, fill} + 1'b1;
    fill_sat   = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
    len_mask   = '0;
    for (int i = 0; i < PAT_MAX; i++)
      len_mask[i] = (32'(i) < 32'(len_q));
    bits_eq    = ((shift_hist ^ pat_q) & len_mask) == '0;
    // a load takes the cycle: din is not sampled when the load is accepted
    match      = bus.din_valid && !load_ok && (fill_sat == len_q) && bits_eq;
  end

  // Next-state: a legal load restarts detection with the new pattern,
  // otherwise a valid bit shifts in; idle cycles hold history and fill.
  always_comb begin
    pat_n  = pat_q;
    len_n  = len_q;
    hist_n = hist;
    fill_n = fill;
    dout_n = 1'b0;
    if (load_ok) begin
      pat_n  = bus.pat_in;
      len_n  = bus.pat_len;
      hist_n = '0;
      fill_n = '0;
    end else if (bus.din_valid) begin
      hist_n = shift_hist;
      dout_n = match;
      // non-overlap: the next match must be built from len_q fresh bits
      if (match) fill_n = bus.overlap_en ? len_q : '0;
      else       fill_n = fill_sat;
    end
  end

  // Next count: clear beats a simultaneous match; increments saturate.
  always_comb begin
    cnt_n = cnt_q;
    if (bus.count_clr)
      cnt_n = '0;
    else if (match && (cnt_q != CNT_MAX))
      cnt_n = cnt_q + 1'b1;
  end

  // State register with synchronous active-high reset to the "1001" default.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= PAT_RST;
      len_q  <= LEN_RST;
      hist   <= '0;
      fill   <= '0;
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_n;
      len_q  <= len_n;
      hist   <= hist_n;
      fill   <= fill_n;
      dout_q <= dout_n;
      cnt_q  <= cnt_n;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.match_count = cnt_q;
  assign bus.pat_len_q   = len_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios followed by a random
// stream, all checked cycle by cycle against a queue-based reference model.
// A second instance with a 2-bit counter shares the stimulus to exercise
// saturation.
module tb_seq_detector_param;
  localparam int PAT_MAX = 8;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_MAX(PAT_MAX), .LEN_W(LEN_W), .CNT_W(16)) bi ();
  seq_detector_param_if #(.PAT_MAX(PAT_MAX), .LEN_W(LEN_W), .CNT_W(2))  bs ();

  assign bs.din        = bi.din;
  assign bs.din_valid  = bi.din_valid;
  assign bs.overlap_en = bi.overlap_en;
  assign bs.pat_load   = bi.pat_load;
  assign bs.pat_in     = bi.pat_in;
  assign bs.pat_len    = bi.pat_len;
  assign bs.count_clr  = bi.count_clr;

  seq_detector_param #(.PAT_MAX(PAT_MAX), .LEN_W(LEN_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bi));
  seq_detector_param #(.PAT_MAX(PAT_MAX), .LEN_W(LEN_W), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .bus(bs));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: bits received since the last restart, oldest first
  bit         hq[$];
  int         m_len;
  logic [7:0] m_pat;
  bit         m_dout;
  int         m_cnt16, m_cnt2;

  // One clock: apply inputs, advance the model, compare every output.
  task automatic step(input bit rst, input bit d, input bit v, input bit ov,
                      input bit ld, input logic [7:0] pin, input logic [3:0] plen,
                      input bit clr);
    bit m;
    reset = rst; bi.din = d; bi.din_valid = v; bi.overlap_en = ov;
    bi.pat_load = ld; bi.pat_in = pin; bi.pat_len = plen; bi.count_clr = clr;
    @(posedge clk);
    #1;
    m = 1'b0;
    if (rst) begin
      hq.delete(); m_pat = 8'b1001; m_len = 4; m_cnt16 = 0; m_cnt2 = 0;
    end else begin
      if (ld && plen >= 1 && int'(plen) <= PAT_MAX) begin
        m_pat = pin; m_len = int'(plen); hq.delete();
      end else if (v) begin
        hq.push_back(d);
        if (hq.size() > m_len) void'(hq.pop_front());
        if (hq.size() == m_len) begin
          m = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (hq[i] != m_pat[m_len-1-i]) m = 1'b0;
        end
        if (m && !ov) hq.delete();
      end
      if (clr) begin
        m_cnt16 = 0; m_cnt2 = 0;
      end else if (m) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    m_dout = m;
    chk("dout",      32'(bi.dout),        32'(m_dout));
    chk("count",     32'(bi.match_count), 32'(m_cnt16));
    chk("count_sat", 32'(bs.match_count), 32'(m_cnt2));
    chk("dout_sat",  32'(bs.dout),        32'(m_dout));
    chk("pat_len_q", 32'(bi.pat_len_q),   32'(m_len));
  endtask

  task automatic send(input bit d, input bit ov);
    step(1'b0, d, 1'b1, ov, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic load(input logic [7:0] pin, input logic [3:0] plen);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pin, plen, 1'b0);
  endtask

  logic [6:0] s1001;

  initial begin
    s1001 = 7'b1001001;
    reset = 1'b1;
    bi.din = 1'b0; bi.din_valid = 1'b0; bi.overlap_en = 1'b0; bi.pat_load = 1'b0;
    bi.pat_in = '0; bi.pat_len = '0; bi.count_clr = 1'b0;
    hq.delete(); m_pat = 8'b1001; m_len = 4; m_cnt16 = 0; m_cnt2 = 0; m_dout = 1'b0;

    do_reset();
    do_reset();
    chk("rst_dout",  32'(bi.dout), 32'd0);
    chk("rst_count", 32'(bi.match_count), 32'd0);
    chk("rst_len",   32'(bi.pat_len_q), 32'd4);

    // default 1001, non-overlap
    for (int i = 6; i >= 0; i--) send(s1001[i], 1'b0);
    chk("nonovl_count", 32'(bi.match_count), 32'd1);

    // same stream, overlapping
    do_reset();
    for (int i = 6; i >= 0; i--) send(s1001[i], 1'b1);
    chk("ovl_count", 32'(bi.match_count), 32'd2);

    // 3-bit pattern 110 with valid gaps
    do_reset();
    load(8'b110, 4'd3);
    chk("load_len", 32'(bi.pat_len_q), 32'd3);
    begin
      logic [5:0] s = 6'b110110;
      for (int i = 5; i >= 0; i--) begin
        send(s[i], 1'b0);
        idle();
        idle();
      end
    end
    chk("gap_count", 32'(bi.match_count), 32'd2);

    // illegal lengths are ignored, 1001 still detected
    do_reset();
    load(8'hff, 4'd0);
    load(8'hff, 4'(PAT_MAX + 1));
    chk("bad_load_len", 32'(bi.pat_len_q), 32'd4);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    chk("bad_load_count", 32'(bi.match_count), 32'd1);

    // length 1, saturation of the 2-bit counter, clear beats match
    do_reset();
    load(8'b1, 4'd1);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
    chk("sat_count", 32'(bs.match_count), 32'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
    chk("clr_wins", 32'(bs.match_count), 32'd0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);

    // reset mid-stream drops partial history
    do_reset();
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
    do_reset();
    send(1'b1, 1'b0);
    chk("mid_rst_nopulse", 32'(bi.dout), 32'd0);
    send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);

    // random stream
    for (int c = 0; c < 4000; c++) begin
      bit rst, ld, v, clr;
      rst = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      step(rst, 1'($urandom), v, 1'($urandom), ld, 8'($urandom),
           4'($urandom_range(0, 10)), clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
